// File: rtl/vdp_register_port_pkg.sv
// Shared definitions for the VDP register port: register offsets, status bit
// positions and the reset value of the pointer increment.
package vdp_register_port_pkg;

  localparam logic [3:0] REG_PTR_LO = 4'h8;
  localparam logic [3:0] REG_PTR_HI = 4'h9;
  localparam logic [3:0] REG_DATA   = 4'hA;
  localparam logic [3:0] REG_INCR   = 4'hB;
  localparam logic [3:0] REG_STATUS = 4'hC;
  localparam logic [3:0] REG_IRQ    = 4'hD;

  localparam int ST_EMPTY    = 0;
  localparam int ST_FULL     = 1;
  localparam int ST_VBLANK   = 2;
  localparam int ST_OVERFLOW = 3;

  localparam logic [7:0] DEFAULT_INCR = 8'h01;

  // Offsets 0-7 address the R0..R7 control register file.
  function automatic logic is_ctrl_reg(input logic [3:0] off);
    return !off[3];
  endfunction

endpackage

// File: rtl/vdp_write_fifo.sv
// Synchronous FIFO buffering CPU VRAM writes until the VDP grants access.
// Extra pointer bit distinguishes full from empty.
module vdp_write_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/vdp_register_port.sv
// CPU-to-VDP register window: control registers, auto-incrementing VRAM pointer
// and a write FIFO drained on vramReady. Define VDP_IRQ_EN to add the irq output.
module vdp_register_port
  import vdp_register_port_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR  = 16'hFFF0,
  parameter int          FIFO_DEPTH = 8,
  parameter int          VADDR_W    = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        address,
  input  logic [7:0]         dataIn,
  input  logic               writeEnable,
  input  logic               readEnable,
  output logic               selected,
  output logic [7:0]         dataOut,
  output logic [63:0]        vdpRegs,
  output logic [VADDR_W-1:0] vramAddr,
  output logic [7:0]         vramData,
  output logic               vramWrite,
  input  logic               vramReady,
  input  logic               vBlank
`ifdef VDP_IRQ_EN
  ,
  output logic               irq
`endif
);

  localparam int FW = VADDR_W + 8;

  logic [7:0][7:0]    regs_q, regs_d;
  logic [VADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]         incr_q, incr_d;
  logic [7:0]         data_out_q, data_out_d;
  logic               vbl_q, vbl_d;
  logic               ovf_q, ovf_d;
  logic               vblank_d_q;
  logic               vram_write_q, vram_write_d;
  logic [VADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [7:0]         vram_data_q, vram_data_d;
`ifdef VDP_IRQ_EN
  logic               irq_en_q, irq_en_d;
`endif

  logic [3:0]    offset;
  logic          wr_hit, rd_hit, data_wr, status_rd, vblank_rise, overflow_evt;
  logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FW-1:0] fifo_head;
  logic [7:0]    status, rd_val;

  assign selected     = (address[15:4] == BASE_ADDR[15:4]);
  assign offset       = address[3:0];
  assign wr_hit       = writeEnable && selected;
  assign rd_hit       = readEnable && selected;
  assign data_wr      = wr_hit && (offset == REG_DATA);
  assign status_rd    = rd_hit && (offset == REG_STATUS);
  assign vblank_rise  = vBlank && !vblank_d_q;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign fifo_pop     = !fifo_empty && vramReady;
  assign fifo_push    = data_wr && (!fifo_full || fifo_pop);
  assign overflow_evt = data_wr && fifo_full && !fifo_pop;

  vdp_write_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata ({ptr_q, dataIn}),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  always_comb begin
    status              = '0;
    status[ST_EMPTY]    = fifo_empty;
    status[ST_FULL]     = fifo_full;
    status[ST_VBLANK]   = vbl_q;
    status[ST_OVERFLOW] = ovf_q;
  end

  always_comb begin
    rd_val = '0;
    if (is_ctrl_reg(offset)) begin
      rd_val = regs_q[offset[2:0]];
    end else begin
      case (offset)
        REG_INCR:   rd_val = incr_q;
        REG_STATUS: rd_val = status;
`ifdef VDP_IRQ_EN
        REG_IRQ:    rd_val = {7'b0, irq_en_q};
`endif
        default:    rd_val = '0;
      endcase
    end
  end

  always_comb begin
    regs_d       = regs_q;
    ptr_d        = ptr_q;
    incr_d       = incr_q;
    data_out_d   = rd_hit ? rd_val : data_out_q;
    vram_write_d = fifo_pop;
    vram_addr_d  = fifo_pop ? fifo_head[FW-1:8] : vram_addr_q;
    vram_data_d  = fifo_pop ? fifo_head[7:0] : vram_data_q;
    // Set events take priority over the clear-on-read of the sticky flags.
    vbl_d        = vblank_rise || (vbl_q && !status_rd);
    ovf_d        = overflow_evt || (ovf_q && !status_rd);
`ifdef VDP_IRQ_EN
    irq_en_d     = irq_en_q;
    if (wr_hit && offset == REG_IRQ) irq_en_d = dataIn[0];
`endif
    if (wr_hit) begin
      if (is_ctrl_reg(offset)) begin
        regs_d[offset[2:0]] = dataIn;
      end else begin
        case (offset)
          REG_PTR_LO: ptr_d[7:0]         = dataIn;
          REG_PTR_HI: ptr_d[VADDR_W-1:8] = dataIn[VADDR_W-9:0];
          REG_DATA:   if (fifo_push) ptr_d = ptr_q + {{(VADDR_W-8){1'b0}}, incr_q};
          REG_INCR:   incr_d             = dataIn;
          default:    ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q       <= '0;
      ptr_q        <= '0;
      incr_q       <= DEFAULT_INCR;
      data_out_q   <= '0;
      vbl_q        <= 1'b0;
      ovf_q        <= 1'b0;
      vblank_d_q   <= 1'b0;
      vram_write_q <= 1'b0;
`ifdef VDP_IRQ_EN
      irq_en_q     <= 1'b0;
`endif
    end else begin
      regs_q       <= regs_d;
      ptr_q        <= ptr_d;
      incr_q       <= incr_d;
      data_out_q   <= data_out_d;
      vbl_q        <= vbl_d;
      ovf_q        <= ovf_d;
      vblank_d_q   <= vBlank;
      vram_write_q <= vram_write_d;
`ifdef VDP_IRQ_EN
      irq_en_q     <= irq_en_d;
`endif
    end
  end

  // Drain datapath: only meaningful while vramWrite is high.
  always_ff @(posedge clk) begin
    vram_addr_q <= vram_addr_d;
    vram_data_q <= vram_data_d;
  end

  assign dataOut   = data_out_q;
  assign vdpRegs   = regs_q;
  assign vramAddr  = vram_addr_q;
  assign vramData  = vram_data_q;
  assign vramWrite = vram_write_q;
`ifdef VDP_IRQ_EN
  assign irq       = vbl_q && irq_en_q;
`endif

endmodule

// File: tb/tb_vdp_register_port.sv
// Self-checking bench for vdp_register_port: directed scenarios plus a
// randomized phase compared against a queue-based reference model.
module tb_vdp_register_port;

  logic        clk = 0;
  logic        reset = 1;
  logic [15:0] address = 16'h0000;
  logic [7:0]  dataIn = 8'h00;
  logic        writeEnable = 0;
  logic        readEnable = 0;
  logic        selected;
  logic [7:0]  dataOut;
  logic [63:0] vdpRegs;
  logic [13:0] vramAddr;
  logic [7:0]  vramData;
  logic        vramWrite;
  logic        vramReady = 0;
  logic        vBlank = 0;
`ifdef VDP_IRQ_EN
  logic        irq;
`endif

  int n_checks = 0;
  int n_errors = 0;

  vdp_register_port dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .dataIn      (dataIn),
    .writeEnable (writeEnable),
    .readEnable  (readEnable),
    .selected    (selected),
    .dataOut     (dataOut),
    .vdpRegs     (vdpRegs),
    .vramAddr    (vramAddr),
    .vramData    (vramData),
    .vramWrite   (vramWrite),
    .vramReady   (vramReady),
    .vBlank      (vBlank)
`ifdef VDP_IRQ_EN
    ,
    .irq         (irq)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: register array, integer pointer, queue of pending writes.
  logic [7:0]  m_regs [8];
  int          m_ptr, m_incr;
  logic [21:0] m_q [$];
  bit          m_vbl, m_ovf, m_vbp, m_vw, m_irqen;
  logic [7:0]  m_dout;
  logic [13:0] m_vaddr;
  logic [7:0]  m_vdata;

  always @(posedge clk) begin : model
    bit          sel, pop, srd, rise, ovfe;
    int          sz, st;
    logic [3:0]  off;
    logic [21:0] ent;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_ptr = 0; m_incr = 1; m_q.delete();
      m_vbl = 0; m_ovf = 0; m_vbp = 0; m_vw = 0; m_irqen = 0; m_dout = 8'h00;
    end else begin
      sel  = (address >= 16'hFFF0);
      off  = address[3:0];
      sz   = m_q.size();
      pop  = (sz > 0) && vramReady;
      srd  = sel && readEnable && (off == 4'hC);
      ovfe = 0;
      if (sel && readEnable) begin
        st = 0;
        if (off < 8) st = int'(m_regs[off[2:0]]);
        else if (off == 4'hB) st = m_incr;
        else if (off == 4'hC) st = (sz == 0 ? 1 : 0) + (sz == 8 ? 2 : 0) + (m_vbl ? 4 : 0) + (m_ovf ? 8 : 0);
`ifdef VDP_IRQ_EN
        else if (off == 4'hD) st = m_irqen ? 1 : 0;
`endif
        m_dout = 8'(st);
      end
      m_vw = pop;
      if (pop) begin
        ent = m_q.pop_front();
        m_vaddr = ent[21:8];
        m_vdata = ent[7:0];
      end
      rise  = vBlank && !m_vbp;
      m_vbp = vBlank;
      if (sel && writeEnable) begin
        if (off < 8) m_regs[off[2:0]] = dataIn;
        else if (off == 4'h8) m_ptr = (m_ptr & 'h3F00) | int'(dataIn);
        else if (off == 4'h9) m_ptr = (m_ptr & 'hFF) | ((int'(dataIn) & 'h3F) << 8);
        else if (off == 4'hA) begin
          if (sz < 8 || pop) begin
            m_q.push_back({14'(m_ptr), dataIn});
            m_ptr = (m_ptr + m_incr) % 16384;
          end else ovfe = 1;
        end
        else if (off == 4'hB) m_incr = int'(dataIn);
        else if (off == 4'hD) m_irqen = dataIn[0];
      end
      m_vbl = rise || (m_vbl && !srd);
      m_ovf = ovfe || (m_ovf && !srd);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    address = a; dataIn = d; writeEnable = 1;
    tick();
    writeEnable = 0;
  endtask

  task automatic cpu_rd(input logic [15:0] a, output logic [7:0] v);
    address = a; readEnable = 1;
    tick();
    readEnable = 0;
    v = dataOut;
  endtask

  task automatic wait_vw(output bit got, output logic [13:0] a, output logic [7:0] d);
    got = 0; a = '0; d = '0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (vramWrite === 1'b1) begin got = 1; a = vramAddr; d = vramData; end
    end
  endtask

  task automatic test_reset();
    logic [7:0] v;
    reset = 1; tick(); tick(); reset = 0;
    n_checks++; if (dataOut !== 8'h00) begin n_errors++; $display("FAIL reset_dout got=%h exp=00", dataOut); end
    n_checks++; if (vramWrite !== 1'b0) begin n_errors++; $display("FAIL reset_vw got=%b exp=0", vramWrite); end
    n_checks++; if (vdpRegs !== 64'h0) begin n_errors++; $display("FAIL reset_regs got=%h exp=0", vdpRegs); end
`ifdef VDP_IRQ_EN
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
`endif
    cpu_rd(16'hFFFC, v);
    n_checks++; if (v !== 8'h01) begin n_errors++; $display("FAIL reset_status got=%h exp=01", v); end
    cpu_rd(16'hFFFB, v);
    n_checks++; if (v !== 8'h01) begin n_errors++; $display("FAIL reset_incr got=%h exp=01", v); end
    cpu_rd(16'hFFFE, v);
    n_checks++; if (v !== 8'h00) begin n_errors++; $display("FAIL read_E got=%h exp=00", v); end
  endtask

  task automatic test_vram_write();
    bit got; logic [13:0] a; logic [7:0] d;
    vramReady = 1;
    cpu_wr(16'hFFF8, 8'h34);
    cpu_wr(16'hFFF9, 8'h12);
    cpu_wr(16'hFFFA, 8'hAB);
    wait_vw(got, a, d);
    n_checks++; if (!got || a !== 14'h1234 || d !== 8'hAB) begin n_errors++; $display("FAIL vram_first got=%0b addr=%h data=%h exp addr=1234 data=AB", got, a, d); end
    tick();
    n_checks++; if (vramWrite !== 1'b0) begin n_errors++; $display("FAIL vram_pulse_width got=%b exp=0", vramWrite); end
    cpu_wr(16'hFFFA, 8'hCD);
    wait_vw(got, a, d);
    n_checks++; if (!got || a !== 14'h1235 || d !== 8'hCD) begin n_errors++; $display("FAIL vram_autoinc got=%0b addr=%h data=%h exp addr=1235 data=CD", got, a, d); end
  endtask

  task automatic test_overflow();
    bit got; logic [13:0] a; logic [7:0] d; logic [7:0] v;
    tick();
    vramReady = 0;
    for (int i = 0; i < 9; i++) cpu_wr(16'hFFFA, 8'(8'h10 + i));
    cpu_rd(16'hFFFC, v);
    n_checks++; if (v !== 8'h0A) begin n_errors++; $display("FAIL ovf_status got=%h exp=0A", v); end
    cpu_rd(16'hFFFC, v);
    n_checks++; if (v !== 8'h02) begin n_errors++; $display("FAIL ovf_cleared got=%h exp=02", v); end
    vramReady = 1;
    for (int i = 0; i < 8; i++) begin
      wait_vw(got, a, d);
      n_checks++; if (!got || a !== 14'(14'h1236 + i) || d !== 8'(8'h10 + i)) begin n_errors++; $display("FAIL ovf_drain%0d got=%0b addr=%h data=%h exp addr=%h data=%h", i, got, a, d, 14'h1236 + i, 8'h10 + i); end
    end
    tick();
    n_checks++; if (vramWrite !== 1'b0) begin n_errors++; $display("FAIL ovf_dropped got=%b exp=0", vramWrite); end
    cpu_rd(16'hFFFC, v);
    n_checks++; if (v !== 8'h01) begin n_errors++; $display("FAIL drained_status got=%h exp=01", v); end
    cpu_wr(16'hFFFA, 8'h99);
    wait_vw(got, a, d);
    n_checks++; if (!got || a !== 14'h123E) begin n_errors++; $display("FAIL ovf_ptr_held got=%0b addr=%h exp=123E", got, a); end
  endtask

  task automatic test_wrap();
    bit got; logic [13:0] a; logic [7:0] d; logic [7:0] v;
    tick();
    vramReady = 0;
    cpu_wr(16'hFFFB, 8'h20);
    cpu_wr(16'hFFF8, 8'hF0);
    cpu_wr(16'hFFF9, 8'h3F);
    cpu_wr(16'hFFFA, 8'h55);
    cpu_wr(16'hFFFA, 8'h66);
    vramReady = 1;
    wait_vw(got, a, d);
    n_checks++; if (!got || a !== 14'h3FF0 || d !== 8'h55) begin n_errors++; $display("FAIL wrap_first got=%0b addr=%h data=%h exp addr=3FF0 data=55", got, a, d); end
    wait_vw(got, a, d);
    n_checks++; if (!got || a !== 14'h0010 || d !== 8'h66) begin n_errors++; $display("FAIL wrap_second got=%0b addr=%h data=%h exp addr=0010 data=66", got, a, d); end
    cpu_rd(16'hFFFB, v);
    n_checks++; if (v !== 8'h20) begin n_errors++; $display("FAIL incr_read got=%h exp=20", v); end
    cpu_wr(16'hFFFB, 8'h01);
  endtask

  task automatic test_vblank();
    logic [7:0] v;
`ifdef VDP_IRQ_EN
    cpu_wr(16'hFFFD, 8'h01);
`endif
    vBlank = 1; tick(); tick();
`ifdef VDP_IRQ_EN
    n_checks++; if (irq !== 1'b1) begin n_errors++; $display("FAIL irq_set got=%b exp=1", irq); end
`endif
    cpu_rd(16'hFFFC, v);
    n_checks++; if (v !== 8'h05) begin n_errors++; $display("FAIL vbl_status got=%h exp=05", v); end
    cpu_rd(16'hFFFC, v);
    n_checks++; if (v !== 8'h01) begin n_errors++; $display("FAIL vbl_cleared got=%h exp=01", v); end
`ifdef VDP_IRQ_EN
    n_checks++; if (irq !== 1'b0) begin n_errors++; $display("FAIL irq_cleared got=%b exp=0", irq); end
`endif
    cpu_rd(16'hFFFD, v);
`ifdef VDP_IRQ_EN
    n_checks++; if (v !== 8'h01) begin n_errors++; $display("FAIL irq_ctl_read got=%h exp=01", v); end
`else
    n_checks++; if (v !== 8'h00) begin n_errors++; $display("FAIL irq_ctl_read got=%h exp=00", v); end
`endif
    vBlank = 0; tick();
  endtask

  task automatic test_regs();
    logic [7:0] v;
    address = 16'hFFF3; #1;
    n_checks++; if (selected !== 1'b1) begin n_errors++; $display("FAIL sel_in got=%b exp=1", selected); end
    cpu_wr(16'hFFF3, 8'h5A);
    n_checks++; if (vdpRegs[31:24] !== 8'h5A) begin n_errors++; $display("FAIL r3_write got=%h exp=5A", vdpRegs[31:24]); end
    cpu_rd(16'hFFF3, v);
    n_checks++; if (v !== 8'h5A) begin n_errors++; $display("FAIL r3_read got=%h exp=5A", v); end
    address = 16'hFFE3; #1;
    n_checks++; if (selected !== 1'b0) begin n_errors++; $display("FAIL sel_out got=%b exp=0", selected); end
    cpu_wr(16'hFFE3, 8'h77);
    n_checks++; if (vdpRegs[31:24] !== 8'h5A) begin n_errors++; $display("FAIL unsel_write got=%h exp=5A", vdpRegs[31:24]); end
    cpu_rd(16'hFFE3, v);
    n_checks++; if (v !== 8'h5A) begin n_errors++; $display("FAIL unsel_read_hold got=%h exp=5A", v); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    logic [63:0] exp;
    cpu_wr(16'hFFF5, 8'h11);
    address = 16'hFFF5; dataIn = 8'h22; writeEnable = 1; readEnable = 1;
    tick();
    writeEnable = 0; readEnable = 0;
    n_checks++; if (dataOut !== 8'h11) begin n_errors++; $display("FAIL rw_old_value got=%h exp=11", dataOut); end
    n_checks++; if (vdpRegs[47:40] !== 8'h22) begin n_errors++; $display("FAIL rw_write got=%h exp=22", vdpRegs[47:40]); end
    exp = '0;
    for (int i = 0; i < 8; i++) begin
      cpu_wr(16'(16'hFFF0 + i), 8'(8'hA0 + 3 * i));
      exp[i*8 +: 8] = 8'(8'hA0 + 3 * i);
    end
    n_checks++; if (vdpRegs !== exp) begin n_errors++; $display("FAIL regs_b2b got=%h exp=%h", vdpRegs, exp); end
    cpu_rd(16'hFFF7, v);
    n_checks++; if (v !== 8'hB5) begin n_errors++; $display("FAIL r7_read got=%h exp=B5", v); end
  endtask

  task automatic test_reset_mid_drain();
    logic [7:0] v;
    int pulses;
    vramReady = 0;
    for (int i = 0; i < 4; i++) cpu_wr(16'hFFFA, 8'(i));
    vramReady = 1; tick();
    reset = 1; tick(); reset = 0;
    n_checks++; if (vramWrite !== 1'b0) begin n_errors++; $display("FAIL rst_drain_vw got=%b exp=0", vramWrite); end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (vramWrite === 1'b1) pulses++; end
    n_checks++; if (pulses != 0) begin n_errors++; $display("FAIL rst_flush pulses=%0d exp=0", pulses); end
    cpu_rd(16'hFFFC, v);
    n_checks++; if (v !== 8'h01) begin n_errors++; $display("FAIL rst_status got=%h exp=01", v); end
  endtask

  task automatic test_random();
    bit sel_exp;
    logic [63:0] exp;
    for (int c = 0; c < 600; c++) begin
      sel_exp     = ($urandom_range(0, 9) != 0);
      address     = (sel_exp ? 16'hFFF0 : 16'hFFE0) | 16'($urandom_range(0, 15));
      if ($urandom_range(0, 2) == 0) address[3:0] = 4'hA;
      dataIn      = 8'($urandom);
      writeEnable = ($urandom_range(0, 2) == 0);
      readEnable  = ($urandom_range(0, 2) == 0);
      vramReady   = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 7) == 0) vBlank = ~vBlank;
      #1;
      n_checks++; if (selected !== sel_exp) begin n_errors++; $display("FAIL rnd_sel c=%0d got=%b exp=%b", c, selected, sel_exp); end
      @(posedge clk); #1;
      for (int i = 0; i < 8; i++) exp[i*8 +: 8] = m_regs[i];
      n_checks++; if (dataOut !== m_dout) begin n_errors++; $display("FAIL rnd_dout c=%0d got=%h exp=%h", c, dataOut, m_dout); end
      n_checks++; if (vdpRegs !== exp) begin n_errors++; $display("FAIL rnd_regs c=%0d got=%h exp=%h", c, vdpRegs, exp); end
      n_checks++; if (vramWrite !== m_vw) begin n_errors++; $display("FAIL rnd_vw c=%0d got=%b exp=%b", c, vramWrite, m_vw); end
      if (m_vw) begin
        n_checks++; if (vramAddr !== m_vaddr || vramData !== m_vdata) begin n_errors++; $display("FAIL rnd_vram c=%0d got=%h/%h exp=%h/%h", c, vramAddr, vramData, m_vaddr, m_vdata); end
      end
`ifdef VDP_IRQ_EN
      n_checks++; if (irq !== (m_vbl && m_irqen)) begin n_errors++; $display("FAIL rnd_irq c=%0d got=%b exp=%b", c, irq, m_vbl && m_irqen); end
`endif
    end
    writeEnable = 0; readEnable = 0; vBlank = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #1;
    test_reset();
    test_vram_write();
    test_overflow();
    test_wrap();
    test_vblank();
    test_regs();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
